// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, the PC register and instruction memory.
// The master modport is the controller side; the slave modport is the surrounding pipeline.
`timescale 1ns/1ps
interface fetch_ctrl_if #(
    parameter int unsigned PC_W = 32
);
    logic            stall_i;
    logic            exc_req_i;
    logic            jump_req_i;
    logic [PC_W-1:0] jump_addr_i;
    logic            branch_req_i;
    logic [PC_W-1:0] branch_addr_i;
    logic            imem_ack_i;

    logic            imem_req_o;
    logic            fetch_valid_o;
    logic            pc_enable_o;
    logic            pc_stall_o;
    logic            pc_use_new_addr_o;
    logic [PC_W-1:0] pc_addr_o;
    logic            redirect_taken_o;

    modport master (
        input  stall_i, exc_req_i, jump_req_i, jump_addr_i,
               branch_req_i, branch_addr_i, imem_ack_i,
        output imem_req_o, fetch_valid_o, pc_enable_o, pc_stall_o,
               pc_use_new_addr_o, pc_addr_o, redirect_taken_o
    );

    modport slave (
        output stall_i, exc_req_i, jump_req_i, jump_addr_i,
               branch_req_i, branch_addr_i, imem_ack_i,
        input  imem_req_o, fetch_valid_o, pc_enable_o, pc_stall_o,
               pc_use_new_addr_o, pc_addr_o, redirect_taken_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences memory reads, PC advance and redirects,
// discarding the response of a read that was in flight when the PC was redirected.
`timescale 1ns/1ps
module fetch_ctrl #(
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL
    } state_e;

    state_e          state_q, state_d;
    logic            squash_q, squash_d;
    logic            redirect;
    logic [PC_W-1:0] target;

    // Redirect requests are only honoured once the controller has left IDLE.
    always_comb begin
        redirect = (state_q != IDLE) &&
                   (bus.exc_req_i || bus.jump_req_i || bus.branch_req_i);
        target   = '0;
        if (bus.exc_req_i) begin
            target = EXC_VECTOR;
        end else if (bus.jump_req_i) begin
            target = bus.jump_addr_i;
        end else if (bus.branch_req_i) begin
            target = bus.branch_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        case (state_q)
            IDLE: begin
                state_d  = FETCH;
                squash_d = 1'b0;
            end
            FETCH: begin
                if (redirect) begin
                    // A read still in flight belongs to the old path; an ack arriving
                    // with the redirect retires that read, but never clears a pending squash.
                    squash_d = squash_q | ~bus.imem_ack_i;
                end else if (bus.imem_ack_i) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                    end else if (bus.stall_i) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (redirect || !bus.stall_i) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d  = IDLE;
                squash_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.imem_req_o        = 1'b0;
        bus.fetch_valid_o     = 1'b0;
        bus.pc_enable_o       = 1'b0;
        bus.pc_stall_o        = 1'b0;
        bus.pc_use_new_addr_o = 1'b0;
        bus.pc_addr_o         = '0;
        bus.redirect_taken_o  = 1'b0;
        case (state_q)
            FETCH: begin
                bus.pc_enable_o = 1'b1;
                bus.imem_req_o  = 1'b1;
                if (redirect) begin
                    bus.pc_use_new_addr_o = 1'b1;
                    bus.pc_addr_o         = target;
                    bus.redirect_taken_o  = 1'b1;
                end else if (bus.imem_ack_i && !squash_q) begin
                    bus.fetch_valid_o = 1'b1;
                    bus.pc_stall_o    = bus.stall_i;
                end else begin
                    bus.pc_stall_o = 1'b1;
                end
            end
            STALL: begin
                bus.pc_enable_o = 1'b1;
                if (redirect) begin
                    bus.pc_use_new_addr_o = 1'b1;
                    bus.pc_addr_o         = target;
                    bus.redirect_taken_o  = 1'b1;
                end else begin
                    bus.pc_stall_o = bus.stall_i;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the fetch rules.
`timescale 1ns/1ps
module tb_fetch_ctrl;
    localparam logic [31:0] EXC = 32'h0000_0180;

    logic clk;
    logic reset_n_i;
    int   vectors;
    int   miscompares;

    fetch_ctrl_if #(.PC_W(32)) bus ();

    fetch_ctrl #(.PC_W(32), .EXC_VECTOR(EXC)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n_i),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {imem_req, fetch_valid, pc_enable, pc_stall, use_new, redirect_taken, pc_addr}
    logic [37:0] obs;
    logic [37:0] exp_v;
    assign obs = {bus.imem_req_o, bus.fetch_valid_o, bus.pc_enable_o, bus.pc_stall_o,
                  bus.pc_use_new_addr_o, bus.redirect_taken_o, bus.pc_addr_o};

    // Model: running = left idle; holding = a delivered word is waiting on the stall;
    // discard_next = the next memory response belongs to an abandoned path.
    bit m_running, m_holding, m_discard_next;

    task automatic model_reset();
        m_running      = 0;
        m_holding      = 0;
        m_discard_next = 0;
    endtask

    task automatic apply(input bit stl, input bit exc, input bit jmp, input logic [31:0] ja,
                         input bit br, input logic [31:0] ba, input bit ack);
        bit e_req, e_val, e_en, e_stall, e_new, e_taken;
        logic [31:0] e_addr;
        @(negedge clk);
        bus.stall_i       = stl;
        bus.exc_req_i     = exc;
        bus.jump_req_i    = jmp;
        bus.jump_addr_i   = ja;
        bus.branch_req_i  = br;
        bus.branch_addr_i = ba;
        bus.imem_ack_i    = ack;
        #1;
        {e_req, e_val, e_en, e_stall, e_new, e_taken} = '0;
        e_addr = '0;
        if (!m_running) begin
            m_running = 1;
        end else begin
            e_en  = 1;
            e_req = !m_holding;
            if (exc || jmp || br) begin
                e_new   = 1;
                e_taken = 1;
                e_addr  = exc ? EXC : (jmp ? ja : ba);
                if (m_holding) m_holding = 0;
                else if (!ack) m_discard_next = 1;
            end else if (m_holding) begin
                e_stall = stl;
                if (!stl) m_holding = 0;
            end else if (ack && m_discard_next) begin
                e_stall        = 1;
                m_discard_next = 0;
            end else if (ack) begin
                e_val     = 1;
                e_stall   = stl;
                m_holding = stl;
            end else begin
                e_stall = 1;
            end
        end
        exp_v = {e_req, e_val, e_en, e_stall, e_new, e_taken, e_addr};
    endtask

    task automatic idle_inputs();
        bus.stall_i = 0; bus.exc_req_i = 0; bus.jump_req_i = 0; bus.jump_addr_i = '0;
        bus.branch_req_i = 0; bus.branch_addr_i = '0; bus.imem_ack_i = 0;
    endtask

    task automatic test_reset();
        bus.stall_i = 1; bus.exc_req_i = 1; bus.jump_req_i = 1; bus.jump_addr_i = 32'hDEAD_BEEF;
        bus.branch_req_i = 1; bus.branch_addr_i = 32'h1234_5678; bus.imem_ack_i = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h expected %h", obs, 38'h0);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        reset_n_i = 1;
        model_reset();
    endtask

    task automatic test_ack_every_2nd();
        for (int i = 0; i < 12; i++) begin
            apply(0, 0, 0, '0, 0, '0, (i % 2) == 1);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL ack_every_2nd[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_jump_squash();
        bit acks[4] = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, i == 0, 32'h0000_4000, 0, '0, acks[i]);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL jump_squash[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        // Redirect coinciding with an ack: the next ack is already on the new path.
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, i == 0, 32'h0000_2000, 0, '0, i != 1);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL jump_with_ack[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 4; i++) begin
            apply(0, i == 0, i <= 1, 32'h0000_3000, i <= 2, 32'h0000_5000, i == 3);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL priority[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        apply(0, 0, 0, '0, 0, '0, 1);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL priority_drain: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_stall();
        bit stl[5] = '{1, 1, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            apply(stl[i], 0, 0, '0, 0, '0, i == 0 || i == 4);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_branch_in_stall();
        for (int i = 0; i < 4; i++) begin
            apply(i <= 1, 0, 0, '0, i == 1, 32'h0000_0100, i != 1 && i != 2);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL branch_in_stall[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        apply(0, 0, 0, '0, 0, '0, 0);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL pre_reset_fetch: got %h expected %h", obs, exp_v);
        end
        #2;
        reset_n_i = 0;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %h expected %h", obs, 38'h0);
        end
        bus.imem_ack_i = 1;
        bus.jump_req_i = 1;
        @(posedge clk); #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL async_reset_held: got %h expected %h", obs, 38'h0);
        end
        @(posedge clk); #1;
        idle_inputs();
        reset_n_i = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, '0, 0, '0, i != 1);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL late_ack_after_reset[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 2) == 0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n_i   = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_ack_every_2nd();
        test_jump_squash();
        test_priority();
        test_stall();
        test_branch_in_stall();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0180, exception redirect target.
REQ-002 SHALL have parameter PC_W, default 32, width of all address ports (matches `PC_SIZE).
REQ-003 clk_i  in  1  sole clock; all state updates on the active (`EDGE_WRITE) edge.
REQ-004 reset_n_i  in  1  asynchronous, active-low reset.
REQ-005 stall_i  in  1  downstream hazard stall; holds the PC advance.
REQ-006 exc_req_i  in  1  exception redirect request, 1-cycle pulse.
REQ-007 jump_req_i  in  1  jump redirect request, 1-cycle pulse.
REQ-008 jump_addr_i  in  PC_W  jump target.
REQ-009 branch_req_i  in  1  taken-branch redirect request, 1-cycle pulse.
REQ-010 branch_addr_i  in  PC_W  branch target.
REQ-011 imem_ack_i  in  1  instruction memory read done, 1-cycle pulse.
REQ-012 imem_req_o  out  1  instruction fetch request at current PC.
REQ-013 fetch_valid_o  out  1  fetched word is valid this cycle.
REQ-014 pc_enable_o  out  1  drives PC enable.
REQ-015 pc_stall_o  out  1  drives PC stall.
REQ-016 pc_use_new_addr_o  out  1  drives PC load-select.
REQ-017 pc_addr_o  out  PC_W  drives PC load value.
REQ-018 redirect_taken_o  out  1  a redirect was applied this cycle.

Function
REQ-019 States: IDLE, FETCH, STALL; one-hot or binary encoding free.
REQ-020 IDLE: all outputs 0; unconditional transition to FETCH next edge; redirects ignored.
REQ-021 FETCH/STALL: pc_enable_o=1; imem_req_o=1 only in FETCH.
REQ-022 pc_stall_o=0 only in a commit cycle, else 1; commit = PC advance or redirect.
REQ-023 Redirect priority: exc > jump > branch; selected target on pc_addr_o, pc_use_new_addr_o=1, pc_stall_o=0, redirect_taken_o=1, all combinational in the request cycle.
REQ-024 Redirect overrides stall_i; lower-priority simultaneous requests dropped, no queuing.
REQ-025 pc_addr_o=0 and pc_use_new_addr_o=0 when no redirect.
REQ-026 FETCH, ack, no redirect, no squash, stall_i=0: fetch_valid_o=1, PC advance (pc_stall_o=0, use_new=0), stay FETCH.
REQ-027 FETCH, ack, no redirect, no squash, stall_i=1: fetch_valid_o=1, no advance, go STALL.
REQ-028 STALL, stall_i=0, no redirect: PC advance this cycle, go FETCH.
REQ-029 STALL, redirect: apply, go FETCH, no squash set.
REQ-030 FETCH, redirect, no ack same cycle: apply, set squash flag (in-flight read stale).
REQ-031 FETCH, redirect with ack same cycle: fetch_valid_o=0, apply, squash not set, stay FETCH.
REQ-032 FETCH, ack with squash=1: fetch_valid_o=0, no advance, clear squash, stay FETCH, imem_req_o stays 1.
REQ-033 FETCH, ack with squash=1 and new redirect: apply, squash stays 1.
REQ-034 imem_ack_i outside FETCH ignored.

Reset
REQ-035 reset_n_i=0 SHALL immediately force IDLE, squash=0, all outputs 0, regardless of clock.
REQ-036 Reset mid-fetch SHALL abandon the outstanding request; a late ack after release is ignored while in IDLE.

Verification
REQ-037 Release reset, ack every 2nd cycle, stall_i=0 -> IDLE 1 cycle, then pc_stall_o=0 once per ack, fetch_valid_o pulses match acks.
REQ-038 FETCH, jump_req_i with jump_addr_i=32'h0000_4000, ack next cycle -> pc_addr_o=32'h4000, use_new=1 that cycle; following ack fetch_valid_o=0; next ack fetch_valid_o=1.
REQ-039 exc_req_i, jump_req_i, branch_req_i same cycle -> pc_addr_o=EXC_VECTOR, redirect_taken_o=1 once.
REQ-040 ack with stall_i=1 for 3 cycles -> STALL, pc_stall_o=1 three cycles, imem_req_o=0, advance on cycle stall_i drops.
REQ-041 branch_req_i in STALL with branch_addr_i=32'h0000_0100 -> commit to 32'h100, FETCH, next ack valid.
REQ-042 reset_n_i low between clock edges during FETCH -> outputs 0 immediately; ack one cycle after release -> fetch_valid_o=0.
